// File: rtl/ex_flag_stage.sv
// Execute-to-memory boundary stage.
// Registers the execute result and its writeback sideband, keeps the
// architectural Z/V/N flags, counts retired instructions and latches halt.
// The branch condition for the op in decode is evaluated against the
// registered flags only. The hazard unit stalls decode behind flag writers,
// so no same-cycle flag bypass is needed.
module ex_flag_stage #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] result,
    input  logic              ovfl,
    input  logic [3:0]        dst_reg,
    input  logic              reg_write,
    input  logic [2:0]        cond,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_result,
    output logic [3:0]        out_dst_reg,
    output logic              out_reg_write,
    output logic              flag_z,
    output logic              flag_v,
    output logic              flag_n,
    output logic              branch_taken,
    output logic              halted,
    output logic [CNT_W-1:0]  retired_cnt
);

    // Opcodes that matter to this stage.
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Branch condition codes.
    localparam logic [2:0] CC_NEQ    = 3'b000;
    localparam logic [2:0] CC_EQ     = 3'b001;
    localparam logic [2:0] CC_GT     = 3'b010;
    localparam logic [2:0] CC_LT     = 3'b011;
    localparam logic [2:0] CC_GTE    = 3'b100;
    localparam logic [2:0] CC_LTE    = 3'b101;
    localparam logic [2:0] CC_OVFL   = 3'b110;
    localparam logic [2:0] CC_UNCOND = 3'b111;

    // An op retires only when it is real, the machine is running, and the
    // stage is neither flushed nor stalled this cycle. A flushed op is
    // therefore never accepted, so flush and normal edges share one path.
    logic accept;
    logic cnt_full;

    assign accept   = in_valid & ~halted & ~flush & ~stall;
    assign cnt_full = (retired_cnt == {CNT_W{1'b1}});

    // Pipeline register: result, destination and write-enable sideband.
    // NOTE: sequential state uses non-blocking assignments so every register
    // in the stage samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_dst_reg   <= '0;
            out_reg_write <= 1'b0;
        end else if (flush || !stall) begin
            // Bubble unless accepted; write enable never outlives valid.
            out_valid     <= accept;
            out_reg_write <= accept & reg_write;
            if (accept) begin
                out_result  <= result;
                out_dst_reg <= dst_reg;
            end
        end
    end

    // Architectural flags: arithmetic ops set Z/N/V, logic/shift ops set Z only.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_z <= 1'b0;
            flag_v <= 1'b0;
            flag_n <= 1'b0;
        end else if (accept) begin
            case (op)
                OP_ADD, OP_SUB: begin
                    flag_z <= (result == '0);
                    flag_n <= result[DATA_W-1];
                    flag_v <= ovfl;
                end
                OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
                    flag_z <= (result == '0);
                end
                default: ;
            endcase
        end
    end

    // Sticky halt and saturating retired-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            halted      <= 1'b0;
            retired_cnt <= '0;
        end else if (accept) begin
            if (op == OP_HLT) begin
                halted <= 1'b1;
            end
            if (!cnt_full) begin
                retired_cnt <= retired_cnt + 1'b1;
            end
        end
    end

    // Branch condition evaluated against the registered flags only.
    // NOTE: assigning a default before the case keeps this purely
    // combinational; a missed path would otherwise infer a latch.
    always_comb begin
        branch_taken = 1'b0;
        case (cond)
            CC_NEQ:    branch_taken = ~flag_z;
            CC_EQ:     branch_taken = flag_z;
            CC_GT:     branch_taken = ~flag_z & ~flag_n;
            CC_LT:     branch_taken = flag_n;
            CC_GTE:    branch_taken = flag_z | (~flag_z & ~flag_n);
            CC_LTE:    branch_taken = flag_n | flag_z;
            CC_OVFL:   branch_taken = flag_v;
            CC_UNCOND: branch_taken = 1'b1;
            default:   branch_taken = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_ex_flag_stage.sv
// Directed bench for ex_flag_stage. The counter is built 4 bits wide so
// saturation is reachable in a few cycles. Inputs change #1 after the rising
// edge and outputs are sampled at the same point.
module tb_ex_flag_stage;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_LW  = 4'b1000;
    localparam logic [3:0] OP_HLT = 4'b1111;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall;
    logic              flush;
    logic              in_valid;
    logic [3:0]        op;
    logic [DATA_W-1:0] result;
    logic              ovfl;
    logic [3:0]        dst_reg;
    logic              reg_write;
    logic [2:0]        cond;
    logic              out_valid;
    logic [DATA_W-1:0] out_result;
    logic [3:0]        out_dst_reg;
    logic              out_reg_write;
    logic              flag_z;
    logic              flag_v;
    logic              flag_n;
    logic              branch_taken;
    logic              halted;
    logic [CNT_W-1:0]  retired_cnt;

    int checks = 0;
    int errors = 0;

    ex_flag_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .in_valid      (in_valid),
        .op            (op),
        .result        (result),
        .ovfl          (ovfl),
        .dst_reg       (dst_reg),
        .reg_write     (reg_write),
        .cond          (cond),
        .out_valid     (out_valid),
        .out_result    (out_result),
        .out_dst_reg   (out_dst_reg),
        .out_reg_write (out_reg_write),
        .flag_z        (flag_z),
        .flag_v        (flag_v),
        .flag_n        (flag_n),
        .branch_taken  (branch_taken),
        .halted        (halted),
        .retired_cnt   (retired_cnt)
    );

    always #5 clk = ~clk;

    // Safety net: the sequence below is fixed-length, this only guards a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 time units");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        op        = 4'h0;
        result    = '0;
        ovfl      = 1'b0;
        dst_reg   = 4'h0;
        reg_write = 1'b0;
    endtask

    task automatic drive(input logic [3:0] o, input logic [15:0] r, input logic v,
                         input logic [3:0] d, input logic w);
        in_valid  = 1'b1;
        op        = o;
        result    = r;
        ovfl      = v;
        dst_reg   = d;
        reg_write = w;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Reference condition table for the sweep.
    function automatic logic exp_branch(input logic [2:0] c, input logic z,
                                        input logic n, input logic v);
        case (c)
            3'b000:  return !z;
            3'b001:  return z;
            3'b010:  return !z && !n;
            3'b011:  return n;
            3'b100:  return z || (!z && !n);
            3'b101:  return n || z;
            3'b110:  return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic test_reset();
        idle();
        cond = 3'b110;
        rst  = 1'b1;
        drive(OP_ADD, 16'h8000, 1'b1, 4'd3, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({out_valid, out_reg_write, out_dst_reg, out_result, flag_z, flag_n, flag_v,
                 halted, retired_cnt, branch_taken} !== '0) begin
                errors++;
                $display("FAIL reset_state[%0d]: got v=%b w=%b d=%h r=%h znv=%b%b%b h=%b cnt=%h bt=%b, want all zero",
                         i, out_valid, out_reg_write, out_dst_reg, out_result, flag_z, flag_n,
                         flag_v, halted, retired_cnt, branch_taken);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({out_valid, out_reg_write, out_dst_reg, out_result} !== {1'b1, 1'b1, 4'd3, 16'h8000}) begin
            errors++;
            $display("FAIL reset_release_out: got v=%b w=%b d=%h r=%h, want v=1 w=1 d=3 r=8000",
                     out_valid, out_reg_write, out_dst_reg, out_result);
        end
        checks++;
        if ({flag_z, flag_n, flag_v, retired_cnt, branch_taken} !== {3'b011, 4'd1, 1'b1}) begin
            errors++;
            $display("FAIL reset_release_state: got znv=%b%b%b cnt=%0d bt=%b, want znv=011 cnt=1 bt=1",
                     flag_z, flag_n, flag_v, retired_cnt, branch_taken);
        end
        idle();
    endtask

    task automatic test_add_sll();
        do_reset();
        drive(OP_ADD, 16'h8000, 1'b1, 4'd1, 1'b1);
        tick();
        checks++;
        if ({flag_z, flag_n, flag_v} !== 3'b011) begin
            errors++;
            $display("FAIL add_flags: got znv=%b%b%b, want 011", flag_z, flag_n, flag_v);
        end
        drive(OP_SLL, 16'h0000, 1'b0, 4'd2, 1'b1);
        tick();
        idle();
        checks++;
        if ({flag_z, flag_n, flag_v, out_result, retired_cnt} !== {3'b111, 16'h0000, 4'd2}) begin
            errors++;
            $display("FAIL sll_flags: got znv=%b%b%b r=%h cnt=%0d, want znv=111 r=0000 cnt=2",
                     flag_z, flag_n, flag_v, out_result, retired_cnt);
        end
        cond = 3'b011;
        #1;
        checks++;
        if (branch_taken !== 1'b1) begin
            errors++;
            $display("FAIL sll_branch_lt: got %b, want 1", branch_taken);
        end
        cond = 3'b010;
        #1;
        checks++;
        if (branch_taken !== 1'b0) begin
            errors++;
            $display("FAIL sll_branch_gt: got %b, want 0", branch_taken);
        end
    endtask

    task automatic test_non_flag();
        do_reset();
        drive(OP_SUB, 16'h0005, 1'b0, 4'd4, 1'b0);
        tick();
        checks++;
        if ({flag_z, flag_n, flag_v, out_result, out_reg_write} !== {3'b000, 16'h0005, 1'b0}) begin
            errors++;
            $display("FAIL sub_out: got znv=%b%b%b r=%h w=%b, want znv=000 r=0005 w=0",
                     flag_z, flag_n, flag_v, out_result, out_reg_write);
        end
        drive(OP_LW, 16'h0000, 1'b1, 4'd7, 1'b1);
        tick();
        checks++;
        if ({flag_z, flag_n, flag_v} !== 3'b000) begin
            errors++;
            $display("FAIL lw_flags_hold: got znv=%b%b%b, want 000", flag_z, flag_n, flag_v);
        end
        checks++;
        if ({out_valid, out_reg_write, out_dst_reg, out_result} !== {1'b1, 1'b1, 4'd7, 16'h0000}) begin
            errors++;
            $display("FAIL lw_out: got v=%b w=%b d=%h r=%h, want v=1 w=1 d=7 r=0000",
                     out_valid, out_reg_write, out_dst_reg, out_result);
        end
        // A bubble clears valid/write but keeps the last result and destination.
        idle();
        reg_write = 1'b1;
        result    = 16'h1234;
        tick();
        checks++;
        if ({out_valid, out_reg_write, out_dst_reg, out_result, retired_cnt} !==
            {1'b0, 1'b0, 4'd7, 16'h0000, 4'd2}) begin
            errors++;
            $display("FAIL bubble_out: got v=%b w=%b d=%h r=%h cnt=%0d, want v=0 w=0 d=7 r=0000 cnt=2",
                     out_valid, out_reg_write, out_dst_reg, out_result, retired_cnt);
        end
        idle();
    endtask

    task automatic test_stall_flush();
        do_reset();
        drive(OP_ADD, 16'h0005, 1'b0, 4'd2, 1'b1);
        tick();
        drive(OP_SUB, 16'h0000, 1'b0, 4'd6, 1'b1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({out_valid, out_reg_write, out_dst_reg, out_result, flag_z, retired_cnt} !==
                {1'b1, 1'b1, 4'd2, 16'h0005, 1'b0, 4'd1}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%b w=%b d=%h r=%h z=%b cnt=%0d, want v=1 w=1 d=2 r=0005 z=0 cnt=1",
                         i, out_valid, out_reg_write, out_dst_reg, out_result, flag_z, retired_cnt);
            end
        end
        flush = 1'b1;
        tick();
        checks++;
        if ({out_valid, out_reg_write, out_result, flag_z, retired_cnt} !==
            {1'b0, 1'b0, 16'h0005, 1'b0, 4'd1}) begin
            errors++;
            $display("FAIL stall_flush: got v=%b w=%b r=%h z=%b cnt=%0d, want v=0 w=0 r=0005 z=0 cnt=1",
                     out_valid, out_reg_write, out_result, flag_z, retired_cnt);
        end
        stall = 1'b0;
        flush = 1'b0;
        tick();
        checks++;
        if ({out_valid, out_dst_reg, out_result, flag_z, retired_cnt} !==
            {1'b1, 4'd6, 16'h0000, 1'b1, 4'd2}) begin
            errors++;
            $display("FAIL stall_release: got v=%b d=%h r=%h z=%b cnt=%0d, want v=1 d=6 r=0000 z=1 cnt=2",
                     out_valid, out_dst_reg, out_result, flag_z, retired_cnt);
        end
        // Flush alone: a flag-setting op must not touch flags or the count.
        drive(OP_ADD, 16'h0009, 1'b1, 4'd3, 1'b1);
        flush = 1'b1;
        tick();
        checks++;
        if ({out_valid, out_reg_write, out_result, flag_z, flag_v, retired_cnt} !==
            {1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd2}) begin
            errors++;
            $display("FAIL flush_only: got v=%b w=%b r=%h z=%b v=%b cnt=%0d, want v=0 w=0 r=0000 z=1 v=0 cnt=2",
                     out_valid, out_reg_write, out_result, flag_z, flag_v, retired_cnt);
        end
        idle();
    endtask

    task automatic test_halt();
        do_reset();
        drive(OP_HLT, 16'hABCD, 1'b0, 4'd5, 1'b0);
        tick();
        checks++;
        if ({halted, out_valid, out_result, retired_cnt} !== {1'b1, 1'b1, 16'hABCD, 4'd1}) begin
            errors++;
            $display("FAIL halt_accept: got h=%b v=%b r=%h cnt=%0d, want h=1 v=1 r=abcd cnt=1",
                     halted, out_valid, out_result, retired_cnt);
        end
        drive(OP_ADD, 16'h0000, 1'b1, 4'd1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({halted, out_valid, out_reg_write, out_result, flag_z, flag_v, retired_cnt} !==
                {1'b1, 1'b0, 1'b0, 16'hABCD, 1'b0, 1'b0, 4'd1}) begin
                errors++;
                $display("FAIL halt_ignore[%0d]: got h=%b v=%b w=%b r=%h z=%b v=%b cnt=%0d, want h=1 v=0 w=0 r=abcd z=0 v=0 cnt=1",
                         i, halted, out_valid, out_reg_write, out_result, flag_z, flag_v, retired_cnt);
            end
        end
        do_reset();
        checks++;
        if ({halted, out_valid, retired_cnt} !== {1'b0, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL halt_reset: got h=%b v=%b cnt=%0d, want h=0 v=0 cnt=0",
                     halted, out_valid, retired_cnt);
        end
    endtask

    task automatic test_saturation();
        logic [CNT_W-1:0] exp_cnt;
        do_reset();
        drive(OP_LW, 16'h0042, 1'b0, 4'd9, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick();
            exp_cnt = (i + 1 > 15) ? 4'hF : CNT_W'(i + 1);
            checks++;
            if (retired_cnt !== exp_cnt) begin
                errors++;
                $display("FAIL sat_count[%0d]: got %0d, want %0d", i, retired_cnt, exp_cnt);
            end
        end
        idle();
    endtask

    task automatic test_cond_sweep();
        logic [2:0] combo;
        logic       z;
        logic       n;
        logic       v;
        logic       exp_bt;
        for (int c = 0; c < 8; c++) begin
            combo = 3'(c);
            z = combo[2];
            n = combo[1];
            v = combo[0];
            do_reset();
            // ADD sets N and V directly; Z with N=1 needs a later Z-only op.
            drive(OP_ADD, n ? 16'h8000 : (z ? 16'h0000 : 16'h0001), v, 4'd0, 1'b0);
            tick();
            if (z && n) begin
                drive(OP_XOR, 16'h0000, 1'b0, 4'd0, 1'b0);
                tick();
            end
            idle();
            checks++;
            if ({flag_z, flag_n, flag_v} !== {z, n, v}) begin
                errors++;
                $display("FAIL sweep_flags[%0d]: got znv=%b%b%b, want %b%b%b",
                         c, flag_z, flag_n, flag_v, z, n, v);
            end
            for (int k = 0; k < 8; k++) begin
                cond   = 3'(k);
                exp_bt = exp_branch(cond, z, n, v);
                #1;
                checks++;
                if (branch_taken !== exp_bt) begin
                    errors++;
                    $display("FAIL sweep_cond[znv=%b%b%b cond=%0d]: got %b, want %b",
                             z, n, v, k, branch_taken, exp_bt);
                end
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        cond = 3'b000;
        idle();
        test_reset();
        test_add_sll();
        test_non_flag();
        test_stall_flush();
        test_halt();
        test_saturation();
        test_cond_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_flag_stage.md
Name: ex_flag_stage

Overview:
- Execute-to-memory boundary stage directly downstream of the shifter and ALU.
- Registers the selected 16-bit execute result with its destination/write-enable sideband.
- Maintains the architectural Z/V/N flag register using per-opcode update rules.
- Evaluates the 3-bit branch condition against the registered flags, counts retired instructions, and latches halt.

Parameters:
- DATA_W, 16, width of result datapath.
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold all stage state this cycle.
- flush  input  1  convert the incoming op to a bubble.
- in_valid  input  1  incoming op is real.
- op  input  4  opcode of incoming op.
- result  input  DATA_W  execute result (shifter/ALU mux output).
- ovfl  input  1  signed-overflow indication from the adder for ADD/SUB.
- dst_reg  input  4  destination register index.
- reg_write  input  1  incoming op writes the register file.
- cond  input  3  branch condition code of the op currently in decode.
- out_valid  output  1  registered valid.
- out_result  output  DATA_W  registered result.
- out_dst_reg  output  4  registered destination.
- out_reg_write  output  1  registered write enable, forced 0 when out_valid=0.
- flag_z, flag_v, flag_n  output  1 each  architectural flags.
- branch_taken  output  1  combinational condition evaluation.
- halted  output  1  sticky halt.
- retired_cnt  output  CNT_W  saturating count of accepted valid ops.

Behaviour:
- Reset (rst=1 at edge): all outputs and registers = 0, including flags, halted and retired_cnt. Reset is the highest priority.
- Priority per edge: rst > flush > stall > normal.
- flush=1: out_valid<=0, out_reg_write<=0. Flags, halted and retired_cnt hold. out_result and out_dst_reg hold.
- stall=1 (no flush): every register holds its value; the incoming op is not consumed.
- "accept" = in_valid & ~halted & ~flush & ~stall.
- Normal edge with accept=0:
  - out_valid<=0, out_reg_write<=0.
  - Other registers hold.
- Normal edge with accept=1:
  - out_valid<=1, out_result<=result, out_dst_reg<=dst_reg, out_reg_write<=reg_write.
  - retired_cnt<=retired_cnt+1, saturating at all-ones (no wrap).
- Flag update, only on accept, from result at that edge:
  - ADD 0000 and SUB 0001 set all three flags:
    - Z = (result==0).
    - N = result[DATA_W-1].
    - V = ovfl.
  - XOR 0010, SLL 0100, SRA 0101, ROR 0110 set Z only; V and N hold.
  - All other opcodes leave all flags unchanged.
- HLT 1111 accepted: retired, out_valid<=1, halted<=1, and halted stays 1 until rst. While halted, in_valid is ignored (treated as a bubble).
- Latency: one cycle from input to out_*. Flags are visible on outputs the cycle after the edge that accepts the op.
- branch_taken is combinational from cond and the registered flags only. There is no bypass of same-cycle flag updates; the hazard unit stalls decode one cycle behind a flag-setting op.
- Condition codes:
  - 000 NEQ: ~Z.
  - 001 EQ: Z.
  - 010 GT: ~Z & ~N.
  - 011 LT: N.
  - 100 GTE: Z | (~Z & ~N).
  - 101 LTE: N | Z.
  - 110 OVFL: V.
  - 111 UNCOND: 1.
- Simultaneous stall and flush: flush wins, and the stage emits a bubble.

Test Plan:
- Reset sequencing: rst=1 for 2 cycles with in_valid=1, op=0000, result=16'h8000 -> all outputs 0. First accepted op after release -> out_valid=1, retired_cnt=1.
- ADD then SLL: ADD result=16'h8000, ovfl=1 -> Z=0, N=1, V=1. Then SLL result=16'h0000 -> Z=1, N=1, V=1 (N and V held). cond=011 -> branch_taken=1. cond=010 -> 0.
- Non-flag op: LW op=1000, result=0 following SUB result=16'h0005 -> flags stay Z=0, N=0, V=0. out_result=16'h0000, out_reg_write as driven.
- Stall/flush interplay:
  - stall=1 for 3 cycles with a SUB (result=0) pending -> outputs and flags frozen, retired_cnt unchanged.
  - stall=1 and flush=1 together -> out_valid=0, Z unchanged.
  - Release -> SUB accepted, Z=1.
- Halt: accept HLT -> halted=1, out_valid=1 next cycle. Subsequent ADD with in_valid=1 -> out_valid=0, retired_cnt constant. rst clears halted.
- Counter saturation: with CNT_W=4, accept 20 valid ops -> retired_cnt reaches 4'hF and stays there. Condition sweep: set each Z/N/V combination and check all 8 cond codes against the table.
